// File: rtl/mul_seq_param.sv
// Purpose : sequential shift-add multiplier, unsigned or two's-complement, early exit on zero multiplier.
// Latency : k = max(1, msb index of |b| + 1) cycles from accept to done (1..WIDTH).
// Backpressure: none; start is only honoured in IDLE/DONE, ignored while busy, never queued.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, signed_mode  request and operand mode, sampled on the accept edge
//   a_in, b_in          WIDTH-bit multiplicand / multiplier, sampled on the accept edge
//   busy                high while iterating (CALC)
//   done                one-cycle pulse when product has been updated
//   product             2*WIDTH-bit registered result, held until next completion or reset
module mul_seq_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] ma;
    logic [WIDTH-1:0]   mb;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    // Operand magnitudes; the most negative value negates to itself, which
    // reads correctly as 2^(WIDTH-1) when treated as unsigned.
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               accept;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mb_sh;
    logic               last_iter;

    always_comb begin
        a_mag     = (signed_mode && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
        b_mag     = (signed_mode && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;
        accept    = start && (state != CALC);
        acc_nxt   = mb[0] ? (acc + ma) : acc;
        mb_sh     = mb >> 1;
        // Stop as soon as no multiplier bits remain, or after the final bit.
        last_iter = (mb_sh == '0) || (cnt == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and decoded outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = accept ? CALC : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            ma  <= {{WIDTH{1'b0}}, a_mag};
            mb  <= b_mag;
            acc <= '0;
            cnt <= '0;
            neg <= signed_mode && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
        end else if (state == CALC) begin
            acc <= acc_nxt;
            ma  <= ma << 1;
            mb  <= mb_sh;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                product <= neg ? (~acc_nxt + 1'b1) : acc_nxt;
            end
        end
    end

endmodule
